pwm_cfg_sequencer: RTL and testbench
====================================

Name: pwm_cfg_sequencer

Overview:
AXI4-Lite master that configures the 4-register PWM IP slave (offsets 0x0/0x4/0x8/0xC) from a locally supplied register image. On a start pulse it writes all registers in order, reads each one back, and compares it against the image. It reports done, or an error with a cause and register index. It sits between fabric control logic and the PWM IP's S00_AXI port, replacing processor-driven register setup.

Parameters:
BASE_ADDR, 32'h43C0_0000, byte address of PWM IP register 0
NUM_REGS, 4, registers written/verified (1..4); index counter width 2
TIMEOUT, 1024, max cycles waiting in any single handshake state before abort

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous reset, active-high
start  in  1  single-cycle request; honoured only when not busy
cfg_reg0..cfg_reg3  in  32 each  register image; sampled on accepted start
busy  out  1  high from accepted start until DONE/ERR
done  out  1  level; high after successful verify, cleared by next accepted start
err  out  1  level; high after abort, cleared by next accepted start
err_code  out  2  0 BRESP!=OKAY, 1 RRESP!=OKAY, 2 readback mismatch, 3 timeout
err_idx  out  2  register index at abort
m_axi_awaddr  out  32 ; m_axi_awprot out 3 (const 0); m_axi_awvalid out 1; m_axi_awready in 1
m_axi_wdata  out  32 ; m_axi_wstrb out 4 (const 4'hF); m_axi_wvalid out 1; m_axi_wready in 1
m_axi_bresp  in  2 ; m_axi_bvalid in 1; m_axi_bready out 1
m_axi_araddr  out  32 ; m_axi_arprot out 3 (const 0); m_axi_arvalid out 1; m_axi_arready in 1
m_axi_rdata  in  32 ; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1

Behaviour:
- Reset: state IDLE; all valid/ready outputs, busy, done, err = 0; err_code, err_idx, addresses, wdata = 0; image regs = 0.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE, ERR; index idx 0..NUM_REGS-1.
- IDLE/DONE/ERR + start: latch cfg_reg0..3, clear done/err, idx=0, busy=1, go WR. start while busy is ignored.
- WR: on entry, awvalid=wvalid=1 in the same cycle; awaddr=BASE_ADDR+4*idx; wdata=image[idx]. Each valid drops the cycle after its own handshake (valid&&ready); the two may complete in either order or together. Address/data stay stable while valid. When both are done, go WR_RESP with bready=1.
- WR_RESP: on bvalid, drop bready. If bresp!=2'b00, go ERR (code 0). Else if idx==NUM_REGS-1, set idx=0 and go RD_ADDR; otherwise idx+1 and go WR.
- RD_ADDR: arvalid=1, araddr=BASE_ADDR+4*idx, held until arready; then go RD_DATA with rready=1.
- RD_DATA: on rvalid, drop rready. Check in this priority: rresp!=OKAY -> ERR (code 1); rdata!=image[idx] -> ERR (code 2). Else if last index, go DONE; otherwise idx+1 and go RD_ADDR.
- Never more than one outstanding transaction; reads never overlap writes.
- Timeout: the cycle counter clears on every state entry. Reaching TIMEOUT in WR/WR_RESP/RD_ADDR/RD_DATA -> ERR (code 3). On that transition, all valid/ready outputs are deasserted in the same cycle.
- DONE: done=1, busy=0. ERR: err=1, busy=0, err_code/err_idx held until next accepted start.
- Minimum latency (slave ready every cycle, 1-cycle B/R): 3 cycles per write + 3 per read; done rises by cycle 6*NUM_REGS+2 after start.
- ARESET mid-transaction forces the reset state immediately; the partially issued AXI transfer is abandoned. The slave is assumed to be reset together with the sequencer.

Test Plan:
- Image 0101FFFF/abcd0001/dead0011/beef0011, ready slave -> 4 writes to 0x43C00000..0C, then 4 reads. done=1, err=0, bus addresses in order, no overlap.
- Slave asserts wready 3 cycles before awready on reg1 -> awvalid held until its handshake, wvalid dropped after its own; one write per register; done=1.
- Slave returns BRESP=2'b10 on reg2 -> err=1, err_code=0, err_idx=2, no reads issued.
- Slave corrupts readback of reg3 to beef0010 -> err=1, err_code=2, err_idx=3.
- arready held low 1100 cycles on reg0 read -> err=1, err_code=3, err_idx=0, arvalid=0 after abort.
- start pulsed while busy, and ARESET during WR of reg1 -> the extra start is ignored; after reset all outputs are 0 and a new start completes with done=1.

Source files
------------

// File: rtl/pwm_cfg_sequencer.sv
// AXI4-Lite master that loads a 4-register PWM IP from a local image,
// reads every register back and reports done or an error cause/index.
module pwm_cfg_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h43C0_0000,
    parameter int          NUM_REGS  = 4,
    parameter int          TIMEOUT   = 1024
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        start,
    input  logic [31:0] cfg_reg0,
    input  logic [31:0] cfg_reg1,
    input  logic [31:0] cfg_reg2,
    input  logic [31:0] cfg_reg3,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [1:0]  err_idx,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE, S_ERR
    } state_t;

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [1:0]    LAST     = 2'(NUM_REGS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    logic [1:0]    idx;
    logic [1:0]    idx_inc;
    logic [31:0]   image [4];
    logic          aw_done, w_done;
    logic [TW-1:0] tmo_cnt;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic          aw_fin, w_fin, tmo_hit;
    logic          fail;
    logic [1:0]    fail_code;

    function automatic logic [31:0] reg_addr(input logic [1:0] i);
        return BASE_ADDR + {28'd0, i, 2'b00};
    endfunction

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = 4'hF;

    assign idx_inc = idx + 2'd1;
    assign aw_hs   = m_axi_awvalid & m_axi_awready;
    assign w_hs    = m_axi_wvalid  & m_axi_wready;
    assign b_hs    = m_axi_bvalid  & m_axi_bready;
    assign ar_hs   = m_axi_arvalid & m_axi_arready;
    assign r_hs    = m_axi_rvalid  & m_axi_rready;
    assign aw_fin  = aw_done | aw_hs;
    assign w_fin   = w_done  | w_hs;
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // A completing handshake wins over a timeout landing in the same cycle.
    always_comb begin
        fail      = 1'b0;
        fail_code = 2'd3;
        case (state)
            S_WR:      fail = !(aw_fin && w_fin) && tmo_hit;
            S_WR_RESP: begin
                if (b_hs) begin
                    fail      = (m_axi_bresp != 2'b00);
                    fail_code = 2'd0;
                end else begin
                    fail = tmo_hit;
                end
            end
            S_RD_ADDR: fail = !ar_hs && tmo_hit;
            S_RD_DATA: begin
                if (r_hs) begin
                    if (m_axi_rresp != 2'b00) begin
                        fail      = 1'b1;
                        fail_code = 2'd1;
                    end else if (m_axi_rdata != image[idx]) begin
                        fail      = 1'b1;
                        fail_code = 2'd2;
                    end
                end else begin
                    fail = tmo_hit;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= S_IDLE;
            idx           <= '0;
            tmo_cnt       <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code      <= '0;
            err_idx       <= '0;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_araddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            for (int i = 0; i < 4; i++) image[i] <= '0;
        end else if (fail) begin
            state         <= S_ERR;
            err           <= 1'b1;
            busy          <= 1'b0;
            err_code      <= fail_code;
            err_idx       <= idx;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            if (state inside {S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA})
                tmo_cnt <= tmo_cnt + TW'(1);
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        image[0]      <= cfg_reg0;
                        image[1]      <= cfg_reg1;
                        image[2]      <= cfg_reg2;
                        image[3]      <= cfg_reg3;
                        done          <= 1'b0;
                        err           <= 1'b0;
                        err_code      <= '0;
                        err_idx       <= '0;
                        busy          <= 1'b1;
                        idx           <= '0;
                        m_axi_awaddr  <= reg_addr(2'd0);
                        m_axi_wdata   <= cfg_reg0;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        tmo_cnt       <= '0;
                        state         <= S_WR;
                    end
                end
                S_WR: begin
                    // AW and W complete independently; each valid drops after its own handshake.
                    if (aw_hs) m_axi_awvalid <= 1'b0;
                    if (w_hs)  m_axi_wvalid  <= 1'b0;
                    aw_done <= aw_fin;
                    w_done  <= w_fin;
                    if (aw_fin && w_fin) begin
                        m_axi_bready <= 1'b1;
                        tmo_cnt      <= '0;
                        state        <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (b_hs) begin
                        m_axi_bready <= 1'b0;
                        tmo_cnt      <= '0;
                        if (idx == LAST) begin
                            idx           <= '0;
                            m_axi_araddr  <= reg_addr(2'd0);
                            m_axi_arvalid <= 1'b1;
                            state         <= S_RD_ADDR;
                        end else begin
                            idx           <= idx_inc;
                            m_axi_awaddr  <= reg_addr(idx_inc);
                            m_axi_wdata   <= image[idx_inc];
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= S_WR;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (ar_hs) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        tmo_cnt       <= '0;
                        state         <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (r_hs) begin
                        m_axi_rready <= 1'b0;
                        tmo_cnt      <= '0;
                        if (idx == LAST) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            idx           <= idx_inc;
                            m_axi_araddr  <= reg_addr(idx_inc);
                            m_axi_arvalid <= 1'b1;
                            state         <= S_RD_ADDR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Randomised scoreboard bench for pwm_cfg_sequencer with a behavioural
// AXI4-Lite slave whose ready delays and error responses are configurable.
module tb_pwm_cfg_sequencer;

    localparam logic [31:0] BASE    = 32'h43C0_0000;
    localparam int          N       = 4;
    localparam int          TIMEOUT = 1024;

    logic tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    logic        ARESET, start;
    logic [31:0] img [4];
    logic        busy, done, err;
    logic [1:0]  err_code, err_idx;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    pwm_cfg_sequencer #(.BASE_ADDR(BASE), .NUM_REGS(N), .TIMEOUT(TIMEOUT)) dut (
        .ACLK(tb_ACLK), .ARESET(ARESET), .start(start),
        .cfg_reg0(img[0]), .cfg_reg1(img[1]), .cfg_reg2(img[2]), .cfg_reg3(img[3]),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .err_idx(err_idx),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Scoreboard: {done, err, code, idx} per run, and bus events in order.
    logic [31:0] exp_aw [$];
    logic [31:0] exp_w  [$];
    logic [31:0] exp_ar [$];
    logic [5:0]  exp_res [$];

    int          aw_dly [4];
    int          w_dly  [4];
    int          ar_dly [4];
    int          berr_idx, rerr_idx, corrupt_idx;
    logic [31:0] mem [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errs++;
        $display("FAIL %s: event seen with nothing expected at %0t", name, $time);
    endtask

    function automatic int ridx(input logic [31:0] a);
        logic [31:0] d;
        d = (a - BASE) >> 2;
        return int'(d[1:0]);
    endfunction

    task automatic slave_defaults();
        for (int i = 0; i < 4; i++) begin
            aw_dly[i] = 0;
            w_dly[i]  = 0;
            ar_dly[i] = 0;
        end
        berr_idx    = -1;
        rerr_idx    = -1;
        corrupt_idx = -1;
    endtask

    // Reference model: what the sequencer must do with this image and slave behaviour.
    task automatic push_expect();
        for (int i = 0; i < N; i++) begin
            exp_aw.push_back(BASE + 32'(i * 4));
            exp_w.push_back(img[i]);
            if (berr_idx == i) begin
                exp_res.push_back({2'b01, 2'd0, 2'(i)});
                return;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (ar_dly[i] > TIMEOUT) begin
                exp_res.push_back({2'b01, 2'd3, 2'(i)});
                return;
            end
            exp_ar.push_back(BASE + 32'(i * 4));
            if (rerr_idx == i) begin
                exp_res.push_back({2'b01, 2'd1, 2'(i)});
                return;
            end
            if (corrupt_idx == i) begin
                exp_res.push_back({2'b01, 2'd2, 2'(i)});
                return;
            end
        end
        exp_res.push_back({2'b10, 2'd0, 2'd0});
    endtask

    // Behavioural AXI4-Lite slave.
    initial begin
        logic        h_aw, h_w, h_b, h_ar, h_r, aw_got, w_got;
        logic [31:0] aw_a, w_d, ar_a;
        int          aw_cnt, w_cnt, ar_cnt, k;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
        aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_a = 0; w_d = 0; ar_a = 0;
        forever begin
            @(negedge tb_ACLK);
            h_aw = m_axi_awvalid & m_axi_awready; aw_a = h_aw ? m_axi_awaddr : aw_a;
            h_w  = m_axi_wvalid & m_axi_wready;   w_d  = h_w ? m_axi_wdata : w_d;
            h_b  = m_axi_bvalid & m_axi_bready;
            h_ar = m_axi_arvalid & m_axi_arready; ar_a = h_ar ? m_axi_araddr : ar_a;
            h_r  = m_axi_rvalid & m_axi_rready;
            @(posedge tb_ACLK);
            #1;
            if (ARESET) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_arready = 0; m_axi_rvalid = 0;
                aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                continue;
            end
            if (h_aw) begin
                m_axi_awready = 0; aw_got = 1; aw_cnt = 0;
            end else if (m_axi_awvalid && !aw_got) begin
                if (aw_cnt >= aw_dly[ridx(m_axi_awaddr)]) m_axi_awready = 1;
                else aw_cnt++;
            end
            if (h_w) begin
                m_axi_wready = 0; w_got = 1; w_cnt = 0;
            end else if (m_axi_wvalid && !w_got) begin
                if (w_cnt >= w_dly[ridx(m_axi_awaddr)]) m_axi_wready = 1;
                else w_cnt++;
            end
            if (h_b) m_axi_bvalid = 0;
            if (aw_got && w_got && !m_axi_bvalid) begin
                k = ridx(aw_a);
                m_axi_bresp = (k == berr_idx) ? 2'b10 : 2'b00;
                if (k != berr_idx) mem[k] = w_d;
                m_axi_bvalid = 1; aw_got = 0; w_got = 0;
            end
            if (h_r) m_axi_rvalid = 0;
            if (h_ar) begin
                k = ridx(ar_a);
                m_axi_arready = 0; ar_cnt = 0;
                m_axi_rdata = mem[k] ^ ((k == corrupt_idx) ? 32'd1 : 32'd0);
                m_axi_rresp = (k == rerr_idx) ? 2'b10 : 2'b00;
                m_axi_rvalid = 1;
            end else if (m_axi_arvalid && !m_axi_rvalid) begin
                if (ar_cnt >= ar_dly[ridx(m_axi_araddr)]) m_axi_arready = 1;
                else ar_cnt++;
            end else begin
                ar_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes a bus event or a run.
    initial begin
        logic       prev_busy, aw_prev, w_prev;
        logic [5:0] e;
        prev_busy = 0; aw_prev = 0; w_prev = 0;
        forever begin
            @(negedge tb_ACLK);
            if (aw_prev) chk("awvalid_drop", 32'(m_axi_awvalid), 32'd0);
            if (w_prev)  chk("wvalid_drop", 32'(m_axi_wvalid), 32'd0);
            aw_prev = m_axi_awvalid & m_axi_awready;
            w_prev  = m_axi_wvalid & m_axi_wready;
            if (aw_prev) begin
                if (exp_aw.size() == 0) unexpected("awaddr");
                else chk("awaddr", m_axi_awaddr, exp_aw.pop_front());
                chk("awprot", 32'(m_axi_awprot), 32'd0);
            end
            if (w_prev) begin
                if (exp_w.size() == 0) unexpected("wdata");
                else chk("wdata", m_axi_wdata, exp_w.pop_front());
                chk("wstrb", 32'(m_axi_wstrb), 32'hF);
            end
            if (m_axi_arvalid && m_axi_arready) begin
                if (exp_ar.size() == 0) unexpected("araddr");
                else chk("araddr", m_axi_araddr, exp_ar.pop_front());
                chk("no_overlap", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'd0);
                chk("arprot", 32'(m_axi_arprot), 32'd0);
            end
            if (prev_busy && !busy && !ARESET) begin
                if (exp_res.size() == 0) unexpected("result");
                else begin
                    e = exp_res.pop_front();
                    if (e[5]) chk("result_done", 32'({done, err}), 32'(e[5:4]));
                    else      chk("result_err", 32'({done, err, err_code, err_idx}), 32'(e));
                end
                chk("bus_idle", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                     m_axi_arvalid, m_axi_rready}), 32'd0);
            end
            prev_busy = ARESET ? 1'b0 : busy;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_flags"}, 32'({busy, done, err, err_code, err_idx}), 32'd0);
        chk({tag, "_valids"}, 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                    m_axi_arvalid, m_axi_rready}), 32'd0);
        chk({tag, "_awaddr"}, m_axi_awaddr, 32'd0);
        chk({tag, "_wdata"}, m_axi_wdata, 32'd0);
        chk({tag, "_araddr"}, m_axi_araddr, 32'd0);
    endtask

    // Issue one start and wait for the run to end; optionally pulse start again mid-run.
    task automatic run_seq(input string name, input int extra_at, input bit chk_lat);
        int cyc;
        push_expect();
        @(negedge tb_ACLK); start = 1;
        @(negedge tb_ACLK); start = 0;
        cyc = 1;
        while (busy && cyc < 3000) begin
            @(negedge tb_ACLK);
            cyc++;
            if (cyc == extra_at) begin
                start = 1;
                for (int i = 0; i < 4; i++) img[i] = ~img[i];
            end else begin
                start = 0;
            end
        end
        start = 0;
        if (busy) begin
            n_checks++; n_errs++;
            $display("FAIL %s_timeout: busy still %0d after %0d cycles", name, busy, cyc);
        end
        if (chk_lat) chk({name, "_latency_ok"}, 32'(cyc <= 6 * N + 2), 32'd1);
        @(negedge tb_ACLK);
        chk({name, "_left"}, 32'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_res.size()), 32'd0);
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_res.delete();
    endtask

    initial begin
        int w;
        ARESET = 1; start = 0;
        for (int i = 0; i < 4; i++) begin
            img[i] = '0;
            mem[i] = '0;
        end
        slave_defaults();
        repeat (3) @(negedge tb_ACLK);
        check_all_zero("reset");
        ARESET = 0;

        img[0] = 32'h0101FFFF; img[1] = 32'hABCD0001; img[2] = 32'hDEAD0011; img[3] = 32'hBEEF0011;
        run_seq("basic", -1, 1);
        chk("basic_done_level", 32'({done, err}), 32'h2);

        aw_dly[1] = 3;
        run_seq("aw_late", -1, 0);
        slave_defaults();

        berr_idx = 2;
        run_seq("bresp_err", -1, 0);
        slave_defaults();

        corrupt_idx = 3;
        run_seq("mismatch", -1, 0);
        slave_defaults();

        ar_dly[0] = 1100;
        run_seq("ar_timeout", -1, 0);
        chk("ar_timeout_arvalid", 32'(m_axi_arvalid), 32'd0);
        slave_defaults();

        rerr_idx = 1;
        run_seq("rresp_err", -1, 0);
        slave_defaults();

        img[0] = 32'h11112222; img[1] = 32'h33334444; img[2] = 32'h55556666; img[3] = 32'h77778888;
        run_seq("busy_start", 5, 0);

        // Reset while reg1 is being written; the slave is held off so reg1 never completes.
        img[0] = 32'hCAFE0000; img[1] = 32'hCAFE0001; img[2] = 32'hCAFE0002; img[3] = 32'hCAFE0003;
        aw_dly[1] = 5; w_dly[1] = 5;
        exp_aw.push_back(BASE); exp_w.push_back(img[0]);
        @(negedge tb_ACLK); start = 1;
        @(negedge tb_ACLK); start = 0;
        w = 0;
        while (!(m_axi_awvalid && m_axi_awaddr == BASE + 32'd4) && w < 100) begin
            @(negedge tb_ACLK);
            w++;
        end
        chk("rst_reached_wr1", 32'(w < 100), 32'd1);
        @(negedge tb_ACLK);
        ARESET = 1;
        @(negedge tb_ACLK);
        chk("rst_left", 32'(exp_aw.size() + exp_w.size()), 32'd0);
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_res.delete();
        @(negedge tb_ACLK);
        check_all_zero("midreset");
        ARESET = 0;
        slave_defaults();
        run_seq("after_reset", -1, 0);
        chk("after_reset_done", 32'({done, err}), 32'h2);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 4; i++) begin
                img[i]    = $urandom;
                aw_dly[i] = $urandom_range(0, 3);
                w_dly[i]  = $urandom_range(0, 3);
                ar_dly[i] = $urandom_range(0, 3);
            end
            case ($urandom_range(0, 3))
                1: berr_idx    = $urandom_range(0, N - 1);
                2: rerr_idx    = $urandom_range(0, N - 1);
                3: corrupt_idx = $urandom_range(0, N - 1);
                default: ;
            endcase
            run_seq("random", -1, 0);
            slave_defaults();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errs);
        $fatal(1, "watchdog");
    end

endmodule
